// File: rtl/aes_decipher_round_ctrl_if.sv
// Handshake and datapath-control bundle between the core, the inverse-cipher
// round sequencer and the round datapath.
interface aes_decipher_round_ctrl_if;
  logic       next;
  logic       keylen;
  logic       key_ready;
  logic [1:0] round_type;
  logic [3:0] round_key_idx;
  logic       update_state;
  logic       ready;
  logic       valid;

  // Core side: issues start requests and observes the sequencer outputs.
  modport master (
    output next, keylen, key_ready,
    input  round_type, round_key_idx, update_state, ready, valid
  );

  // Sequencer side.
  modport slave (
    input  next, keylen, key_ready,
    output round_type, round_key_idx, update_state, ready, valid
  );
endinterface

// File: rtl/aes_decipher_round_ctrl.sv
// AES inverse-cipher round sequencer: initial round, NR-1 main rounds, final round.
// Define AES_DECIPHER_CTRL_KEY256_EN to honour keylen (14-round AES-256); otherwise NR is fixed at 10.
module aes_decipher_round_ctrl #(
  parameter logic [1:0] INIT_ROUND  = 2'd0,
  parameter logic [1:0] MAIN_ROUND  = 2'd1,
  parameter logic [1:0] FINAL_ROUND = 2'd2
) (
  input logic                        clk,
  input logic                        reset_n,
  aes_decipher_round_ctrl_if.slave   ctrl_if
);

  localparam logic [3:0] NR_128 = 4'd10;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_MAIN  = 3'd2,
    S_FINAL = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] nr;        // round count of the block in flight
  logic [3:0] nr_start;  // round count for a block starting this cycle
  logic       start;

  assign start = ctrl_if.next & ctrl_if.key_ready;

`ifdef AES_DECIPHER_CTRL_KEY256_EN
  localparam logic [3:0] NR_256 = 4'd14;
  logic keylen_q, keylen_d;

  assign nr       = keylen_q ? NR_256 : NR_128;
  assign nr_start = ctrl_if.keylen ? NR_256 : NR_128;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) keylen_q <= 1'b0;
    else          keylen_q <= keylen_d;
  end
`else
  logic unused_keylen;
  assign unused_keylen = ctrl_if.keylen;
  assign nr            = NR_128;
  assign nr_start      = NR_128;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    state_d               = state_q;
    cnt_d                 = cnt_q;
`ifdef AES_DECIPHER_CTRL_KEY256_EN
    keylen_d              = keylen_q;
`endif
    ctrl_if.round_type    = INIT_ROUND;
    ctrl_if.round_key_idx = 4'd0;
    ctrl_if.update_state  = 1'b0;
    ctrl_if.ready         = 1'b0;
    ctrl_if.valid         = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        ctrl_if.ready = 1'b1;
        ctrl_if.valid = (state_q == S_DONE);
        if (start) begin
          state_d = S_INIT;
          cnt_d   = nr_start;
`ifdef AES_DECIPHER_CTRL_KEY256_EN
          keylen_d = ctrl_if.keylen;
`endif
        end
      end

      S_INIT: begin
        ctrl_if.round_type    = INIT_ROUND;
        ctrl_if.round_key_idx = nr;
        ctrl_if.update_state  = 1'b1;
        cnt_d                 = nr - 4'd1;
        state_d               = S_MAIN;
      end

      S_MAIN: begin
        ctrl_if.round_type    = MAIN_ROUND;
        ctrl_if.round_key_idx = cnt_q;
        ctrl_if.update_state  = 1'b1;
        cnt_d                 = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = S_FINAL;
      end

      S_FINAL: begin
        ctrl_if.round_type    = FINAL_ROUND;
        ctrl_if.round_key_idx = 4'd0;
        ctrl_if.update_state  = 1'b1;
        state_d               = S_DONE;
      end

      // Unreachable encodings recover to IDLE on the next edge.
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_aes_decipher_round_ctrl.sv
// Scoreboard bench for aes_decipher_round_ctrl: stimulus queues the expected
// outputs of every cycle, a negedge monitor pops and compares them.
module tb_aes_decipher_round_ctrl;

  typedef struct packed {
    logic [1:0] rt;
    logic [3:0] idx;
    logic       upd;
    logic       rdy;
    logic       vld;
  } exp_t;

`ifdef AES_DECIPHER_CTRL_KEY256_EN
  localparam int NR_LONG = 14;
`else
  localparam int NR_LONG = 10;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  aes_decipher_round_ctrl_if bus ();

  aes_decipher_round_ctrl dut (
    .clk     (clk),
    .reset_n (reset_n),
    .ctrl_if (bus.slave)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   checks  = 0;
  int   errors  = 0;
  int   cyc     = 0;
  bit   started = 1'b0;

  function automatic exp_t mk(input logic [1:0] rt, input logic [3:0] idx,
                              input logic upd, input logic rdy, input logic vld);
    exp_t e;
    e.rt = rt; e.idx = idx; e.upd = upd; e.rdy = rdy; e.vld = vld;
    return e;
  endfunction

  localparam exp_t IDLE_E = '{rt: 2'd0, idx: 4'd0, upd: 1'b0, rdy: 1'b1, vld: 1'b0};
  localparam exp_t DONE_E = '{rt: 2'd0, idx: 4'd0, upd: 1'b0, rdy: 1'b1, vld: 1'b1};

  task automatic check(input string name, input exp_t got, input exp_t want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got rt=%0d idx=%0d upd=%0b rdy=%0b vld=%0b, required rt=%0d idx=%0d upd=%0b rdy=%0b vld=%0b",
               name, got.rt, got.idx, got.upd, got.rdy, got.vld,
               want.rt, want.idx, want.upd, want.rdy, want.vld);
    end
  endtask

  // Monitor: one expected entry per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    exp_t got;
    got = '{rt: bus.round_type, idx: bus.round_key_idx, upd: bus.update_state,
            rdy: bus.ready, vld: bus.valid};
    if (exp_q.size() != 0) begin
      check($sformatf("cycle%0d", cyc), got, exp_q.pop_front());
    end else if (started) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_underflow: cycle%0d has no expected entry, required one queued", cyc);
    end
    cyc++;
  end

  // Drive one cycle's inputs just after the edge and queue that cycle's outputs.
  task automatic step(input logic n, input logic kl, input logic kr, input logic rn, input exp_t e);
    @(posedge clk);
    #1;
    bus.next      = n;
    bus.keylen    = kl;
    bus.key_ready = kr;
    reset_n       = rn;
    exp_q.push_back(e);
    started = 1'b1;
  endtask

  // Start a block from IDLE/DONE and walk it to FINAL; keylen is flipped after
  // start to show it is ignored, and next may be poked in the MAIN round `poke`.
  task automatic run_block(input logic kl, input int nr, input logic from_done, input int poke);
    step(1'b1, kl, 1'b1, 1'b1, from_done ? DONE_E : IDLE_E);
    step(1'b0, ~kl, 1'b1, 1'b1, mk(2'd0, 4'(nr), 1'b1, 1'b0, 1'b0));
    for (int k = nr - 1; k >= 1; k--)
      step(logic'(k == poke), ~kl, 1'b1, 1'b1, mk(2'd1, 4'(k), 1'b1, 1'b0, 1'b0));
    step(1'b0, ~kl, 1'b1, 1'b1, mk(2'd2, 4'd0, 1'b1, 1'b0, 1'b0));
  endtask

  initial begin
    bus.next = 1'b0; bus.keylen = 1'b0; bus.key_ready = 1'b0;

    // Held in reset, then idle after release.
    repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0, IDLE_E);
    repeat (5) step(1'b0, 1'b0, 1'b1, 1'b1, IDLE_E);

    // next without a valid key is dropped.
    repeat (2) step(1'b1, 1'b0, 1'b0, 1'b1, IDLE_E);
    step(1'b0, 1'b0, 1'b1, 1'b1, IDLE_E);

    // AES-128 block, DONE holds.
    run_block(1'b0, 10, 1'b0, -1);
    repeat (2) step(1'b0, 1'b0, 1'b1, 1'b1, DONE_E);

    // Back-to-back: 128 then 256 (next poked mid-MAIN), no idle gap.
    run_block(1'b0, 10, 1'b1, -1);
    run_block(1'b1, NR_LONG, 1'b1, 5);

    // next without key in DONE leaves valid up.
    repeat (2) step(1'b1, 1'b0, 1'b0, 1'b1, DONE_E);

    // Reset during the 4th MAIN cycle takes effect before the next edge.
    step(1'b1, 1'b0, 1'b1, 1'b1, DONE_E);
    step(1'b0, 1'b0, 1'b1, 1'b1, mk(2'd0, 4'd10, 1'b1, 1'b0, 1'b0));
    for (int k = 9; k >= 7; k--)
      step(1'b0, 1'b0, 1'b1, 1'b1, mk(2'd1, 4'(k), 1'b1, 1'b0, 1'b0));
    step(1'b0, 1'b0, 1'b1, 1'b0, IDLE_E);
    step(1'b1, 1'b0, 1'b1, 1'b0, IDLE_E);
    step(1'b0, 1'b0, 1'b1, 1'b1, IDLE_E);

    // Clean full sequence after the reset.
    run_block(1'b0, 10, 1'b0, -1);
    step(1'b0, 1'b0, 1'b1, 1'b1, DONE_E);
    step(1'b0, 1'b0, 1'b1, 1'b1, DONE_E);

    @(negedge clk);
    #1;
    started = 1'b0;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t, required completion", $time);
    $fatal(1, "timeout");
  end

endmodule
